csr_access_ctrl: RTL

CSR_ACCESS_CTRL -- requirements
Module: csr_access_ctrl

---
 rtl/csr_access_ctrl_pkg.sv | 37 +++
 rtl/csr_ex_prio.sv | 46 ++++
 rtl/csr_access_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/csr_access_ctrl_pkg.sv
// Shared op encodings, exception codes and CSR numbers for the CSR access controller.
// Optional CSRXCHG support is selected by the CSR_XCHG_EN macro in the importing files.
package csr_access_ctrl_pkg;

    localparam logic [2:0] OP_NONE    = 3'd0;
    localparam logic [2:0] OP_CSRRD   = 3'd1;
    localparam logic [2:0] OP_CSRWR   = 3'd2;
    localparam logic [2:0] OP_CSRXCHG = 3'd3;
    localparam logic [2:0] OP_ERTN    = 3'd4;
    localparam logic [2:0] OP_SYSCALL = 3'd5;
    localparam logic [2:0] OP_BREAK   = 3'd6;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    localparam logic [13:0] CSR_SAVE0 = 14'h0030;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_e;

    typedef struct packed {
        logic        valid;
        logic        intr;
        logic [31:0] pc;
        logic [2:0]  op;
        logic [13:0] num;
        logic [31:0] rd;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
    } stage_t;

endpackage

// File: rtl/csr_ex_prio.sv
// Combinational exception priority encoder: INT > upstream > SYSCALL > BREAK > INE.
// INE for CSRXCHG exists only when CSR_XCHG_EN is undefined.
module csr_ex_prio
    import csr_access_ctrl_pkg::*;
(
    input  logic       intr,
    input  logic       in_ex,
    input  logic [5:0] in_ecode,
    input  logic [8:0] in_esubcode,
    input  logic [2:0] op,
    output logic       ex,
    output logic [5:0] ecode,
    output logic [8:0] esubcode
);

    // select the highest-priority cause for the staged beat
    always_comb begin
        ex       = 1'b0;
        ecode    = 6'h00;
        esubcode = 9'h000;
        if (intr) begin
            ex    = 1'b1;
            ecode = ECODE_INT;
        end else if (in_ex) begin
            ex       = 1'b1;
            ecode    = in_ecode;
            esubcode = in_esubcode;
        end else if (op == OP_SYSCALL) begin
            ex    = 1'b1;
            ecode = ECODE_SYS;
        end else if (op == OP_BREAK) begin
            ex    = 1'b1;
            ecode = ECODE_BRK;
`ifndef CSR_XCHG_EN
        end else if (op == OP_CSRXCHG) begin
            ex    = 1'b1;
            ecode = ECODE_INE;
`endif
        end else begin
            ex       = 1'b0;
            ecode    = 6'h00;
            esubcode = 9'h000;
        end
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// CSR access controller: one-entry stage between writeback and the CSR file, plus flush FSM.
// Macro CSR_XCHG_EN enables CSRXCHG; otherwise CSRXCHG raises INE.
module csr_access_ctrl
    import csr_access_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [2:0]  in_op,
    input  logic [13:0] in_csr_num,
    input  logic [31:0] in_rd_data,
    input  logic [31:0] in_rj_data,
    input  logic        in_ex,
    input  logic [5:0]  in_ecode,
    input  logic [8:0]  in_esubcode,
    output logic        out_rf_we,
    output logic [31:0] out_rf_wdata,
    output logic        flush_valid,
    output logic [31:0] flush_target,
    input  logic        flush_ack,
    output logic        csr_we,
    output logic [13:0] csr_wnum,
    output logic [31:0] csr_wvalue,
    output logic [31:0] csr_wmask,
    output logic [13:0] csr_rnum,
    input  logic [31:0] csr_rvalue,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_pc,
    output logic        ertn_flush,
    input  logic [31:0] ex_entry,
    input  logic [31:0] ex_ra,
    input  logic        has_int
);

    stage_t       stg_r;
    flush_state_e state_r;
    logic         flush_valid_r;
    logic [31:0]  flush_target_r;

    logic         ex_s;
    logic [5:0]   ecode_s;
    logic [8:0]   esubcode_s;
    logic         csr_op_s;
    logic         wr_op_s;
    logic [31:0]  mask_s;
    logic         trig_s;

`ifdef CSR_XCHG_EN
    logic [31:0]  stg_rj_r;
`else
    logic         unused_rj_s;
    assign unused_rj_s = ^in_rj_data;
`endif

    csr_ex_prio u_ex_prio (
        .intr        (stg_r.intr),
        .in_ex       (stg_r.ex),
        .in_ecode    (stg_r.ecode),
        .in_esubcode (stg_r.esubcode),
        .op          (stg_r.op),
        .ex          (ex_s),
        .ecode       (ecode_s),
        .esubcode    (esubcode_s)
    );

    // decode the staged op; the stage only holds a beat while in RUN
    always_comb begin
        csr_op_s = 1'b0;
        wr_op_s  = 1'b0;
        mask_s   = 32'hFFFF_FFFF;
        case (stg_r.op)
            OP_CSRRD: begin
                csr_op_s = 1'b1;
            end
            OP_CSRWR: begin
                csr_op_s = 1'b1;
                wr_op_s  = 1'b1;
            end
`ifdef CSR_XCHG_EN
            OP_CSRXCHG: begin
                csr_op_s = 1'b1;
                wr_op_s  = 1'b1;
                mask_s   = stg_rj_r;
            end
`endif
            default: begin
                csr_op_s = 1'b0;
                wr_op_s  = 1'b0;
            end
        endcase
    end

    assign trig_s = stg_r.valid && (ex_s || (stg_r.op == OP_ERTN));

    // stage-driven outputs, gated so an empty stage presents all zeros
    always_comb begin
        csr_we       = 1'b0;
        csr_wnum     = 14'h0000;
        csr_wvalue   = 32'h0000_0000;
        csr_wmask    = 32'h0000_0000;
        csr_rnum     = 14'h0000;
        out_rf_we    = 1'b0;
        out_rf_wdata = 32'h0000_0000;
        wb_ex        = 1'b0;
        wb_ecode     = 6'h00;
        wb_esubcode  = 9'h000;
        wb_pc        = 32'h0000_0000;
        ertn_flush   = 1'b0;
        if (stg_r.valid && ex_s) begin
            wb_ex       = 1'b1;
            wb_ecode    = ecode_s;
            wb_esubcode = esubcode_s;
            wb_pc       = stg_r.pc;
        end else if (stg_r.valid && csr_op_s) begin
            csr_rnum     = stg_r.num;
            out_rf_we    = 1'b1;
            out_rf_wdata = csr_rvalue;
            csr_we       = wr_op_s;
            csr_wnum     = wr_op_s ? stg_r.num : 14'h0000;
            csr_wvalue   = wr_op_s ? stg_r.rd : 32'h0000_0000;
            csr_wmask    = wr_op_s ? mask_s : 32'h0000_0000;
        end else if (stg_r.valid && (stg_r.op == OP_ERTN)) begin
            ertn_flush = 1'b1;
        end else begin
            ertn_flush = 1'b0;
        end
    end

    // stage register: beats accepted in FLUSH or behind a flushing beat are dropped
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stg_r <= '0;
        end else if ((state_r == ST_RUN) && !trig_s && in_valid) begin
            stg_r.valid    <= 1'b1;
            stg_r.intr     <= has_int;
            stg_r.pc       <= in_pc;
            stg_r.op       <= in_op;
            stg_r.num      <= in_csr_num;
            stg_r.rd       <= in_rd_data;
            stg_r.ex       <= in_ex;
            stg_r.ecode    <= in_ecode;
            stg_r.esubcode <= in_esubcode;
        end else begin
            stg_r <= '0;
        end
    end

`ifdef CSR_XCHG_EN
    // xchg mask travels alongside the stage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stg_rj_r <= 32'h0000_0000;
        end else if ((state_r == ST_RUN) && !trig_s && in_valid) begin
            stg_rj_r <= in_rj_data;
        end else begin
            stg_rj_r <= 32'h0000_0000;
        end
    end
`endif

    // flush FSM: hold the redirect until the front end acknowledges it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r        <= ST_RUN;
            flush_valid_r  <= 1'b0;
            flush_target_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (trig_s) begin
                        state_r        <= ST_FLUSH;
                        flush_valid_r  <= 1'b1;
                        flush_target_r <= ex_s ? ex_entry : ex_ra;
                    end else begin
                        state_r        <= ST_RUN;
                        flush_valid_r  <= 1'b0;
                        flush_target_r <= 32'h0000_0000;
                    end
                end
                ST_FLUSH: begin
                    if (flush_ack) begin
                        state_r        <= ST_RUN;
                        flush_valid_r  <= 1'b0;
                        flush_target_r <= 32'h0000_0000;
                    end else begin
                        state_r        <= ST_FLUSH;
                        flush_valid_r  <= 1'b1;
                        flush_target_r <= flush_target_r;
                    end
                end
                default: begin
                    state_r        <= ST_RUN;
                    flush_valid_r  <= 1'b0;
                    flush_target_r <= 32'h0000_0000;
                end
            endcase
        end
    end

    assign in_ready     = 1'b1;
    assign flush_valid  = flush_valid_r;
    assign flush_target = flush_target_r;

endmodule
